// File: rtl/binary_frame_writer.sv
// Packs a 1-bit pixel stream 8 pixels per byte (LSB = leftmost pixel) and writes
// each byte to image memory at y*BYTES_PER_ROW + (x>>3), tracking frame geometry.
module binary_frame_writer #(
   parameter int WIDTH         = 640,
   parameter int HEIGHT        = 480,
   parameter int BYTES_PER_ROW = WIDTH / 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   input  logic        in_pixel,
   input  logic        in_first,
   input  logic        in_last,
   output logic [15:0] wraddress,
   output logic [7:0]  data,
   output logic        wren,
   output logic        frame_done,
   output logic        err
);

   localparam int XW = $clog2(WIDTH + 1);
   localparam int YW = $clog2(HEIGHT + 1);
   localparam logic [XW-1:0] X_MAX = XW'(WIDTH);
   localparam logic [YW-1:0] Y_MAX = YW'(HEIGHT);

   typedef enum logic [1:0] {
      S_WAIT_SOF = 2'd0,
      S_ACTIVE   = 2'd1,
      S_DROP     = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic [7:0]    pack_q, pack_d;
   logic [15:0]   wraddress_q, wraddress_d;
   logic [7:0]    data_q, data_d;
   logic          wren_q, wren_d;
   logic          frame_done_q, frame_done_d;
   logic          err_q, err_d;

   // A beat is in_valid=1; there is no ready, every beat is consumed that cycle.
   // in_first rebases the beat to (0,0) with an empty pack register.
   logic          take;
   logic          in_range;
   logic          byte_done;
   logic [XW-1:0] cx, new_x;
   logic [YW-1:0] cy, line_y;
   logic [7:0]    cpack, new_pack;

   always_comb begin
      state_d      = state_q;
      x_d          = x_q;
      y_d          = y_q;
      pack_d       = pack_q;
      wraddress_d  = wraddress_q;
      data_d       = data_q;
      wren_d       = 1'b0;
      frame_done_d = 1'b0;
      err_d        = err_q;

      take      = in_valid && (in_first || state_q == S_ACTIVE);
      cx        = in_first ? '0 : x_q;
      cy        = in_first ? '0 : y_q;
      cpack     = in_first ? '0 : pack_q;
      in_range  = cx < X_MAX;
      new_pack  = cpack;
      new_x     = cx;
      if (in_range) begin
         new_pack[cx[2:0]] = in_pixel;
         new_x             = cx + 1'b1;
      end
      byte_done = in_range && (cx[2:0] == 3'd7 || in_last);
      line_y    = cy + 1'b1;

      if (take) begin
         state_d = S_ACTIVE;
         // A restart while active aborts the frame; the partial byte is dropped.
         if (in_first && state_q == S_ACTIVE) err_d = 1'b1;
         if (!in_range) err_d = 1'b1;
         x_d    = new_x;
         y_d    = cy;
         pack_d = byte_done ? 8'h00 : new_pack;
         if (byte_done) begin
            wren_d      = 1'b1;
            wraddress_d = 16'(cy) * 16'(BYTES_PER_ROW) + 16'(cx >> 3);
            data_d      = new_pack;
         end
         if (in_last) begin
            x_d    = '0;
            pack_d = 8'h00;
            y_d    = line_y;
            if (new_x != X_MAX) err_d = 1'b1;
            if (line_y == Y_MAX) begin
               frame_done_d = 1'b1;
               y_d          = '0;
               state_d      = S_DROP;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_WAIT_SOF;
         x_q          <= '0;
         y_q          <= '0;
         pack_q       <= 8'h00;
         wraddress_q  <= 16'h0000;
         data_q       <= 8'h00;
         wren_q       <= 1'b0;
         frame_done_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         x_q          <= x_d;
         y_q          <= y_d;
         pack_q       <= pack_d;
         wraddress_q  <= wraddress_d;
         data_q       <= data_d;
         wren_q       <= wren_d;
         frame_done_q <= frame_done_d;
         err_q        <= err_d;
      end
   end

   assign wraddress  = wraddress_q;
   assign data       = data_q;
   assign wren       = wren_q;
   assign frame_done = frame_done_q;
   assign err        = err_q;

endmodule

// File: tb/tb_binary_frame_writer.sv
// Bench for binary_frame_writer: a default 640x480 instance for line-level cases and
// a 16x4 instance for the per-beat vector table and complete-frame cases.
module tb_binary_frame_writer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        d_v, d_p, d_f, d_l, d_wren, d_fd, d_err;
   logic [15:0] d_addr;
   logic [7:0]  d_data;
   logic        s_v, s_p, s_f, s_l, s_wren, s_fd, s_err;
   logic [15:0] s_addr;
   logic [7:0]  s_data;

   binary_frame_writer u_dut (
      .clk(clk), .reset(rst_n), .in_valid(d_v), .in_pixel(d_p), .in_first(d_f),
      .in_last(d_l), .wraddress(d_addr), .data(d_data), .wren(d_wren),
      .frame_done(d_fd), .err(d_err)
   );

   binary_frame_writer #(.WIDTH(16), .HEIGHT(4)) u_small (
      .clk(clk), .reset(rst_n), .in_valid(s_v), .in_pixel(s_p), .in_first(s_f),
      .in_last(s_l), .wraddress(s_addr), .data(s_data), .wren(s_wren),
      .frame_done(s_fd), .err(s_err)
   );

   typedef struct {
      logic        v, p, f, l;
      logic        ew;
      logic [15:0] ea;
      logic [7:0]  ed;
      logic        efd, eerr;
   } vec_t;

   vec_t        tab[$];
   logic [23:0] got_q[$];
   logic [23:0] exp_q[$];
   int          total = 0;
   int          passed = 0;
   int          fd_cnt;
   logic [15:0] fd_addr;
   logic        pix_mem [0:1][0:639];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      {d_v, d_p, d_f, d_l} = 4'b0;
      {s_v, s_p, s_f, s_l} = 4'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      got_q.delete();
      exp_q.delete();
      fd_cnt  = 0;
      fd_addr = 16'hFFFF;
   endtask

   task automatic d_beat(input logic v, input logic p, input logic f, input logic l);
      d_v = v; d_p = p; d_f = f; d_l = l;
      @(posedge clk);
      #1;
      if (d_wren) got_q.push_back({d_addr, d_data});
      if (d_fd) fd_cnt++;
      {d_v, d_f, d_l} = 3'b0;
   endtask

   task automatic s_beat(input logic v, input logic p, input logic f, input logic l);
      s_v = v; s_p = p; s_f = f; s_l = l;
      @(posedge clk);
      #1;
      if (s_wren) got_q.push_back({s_addr, s_data});
      if (s_fd) begin
         fd_cnt++;
         fd_addr = s_wren ? s_addr : 16'hFFFF;
      end
      {s_v, s_f, s_l} = 3'b0;
   endtask

   task automatic compare_writes(input string name);
      int mism;
      mism = 0;
      check({name, " write count"}, got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         if (got_q[i] !== exp_q[i]) mism++;
      check({name, " mismatched writes"}, mism, 0);
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic add(input logic v, p, f, l, ew, input logic [15:0] ea,
                      input logic [7:0] ed, input logic efd, eerr);
      tab.push_back('{v, p, f, l, ew, ea, ed, efd, eerr});
   endtask

   function automatic logic small_pix(input int x, input int y);
      return (x == 1 && y == 1) || (x == 10 && y == 1) || (x == 5 && y == 3);
   endfunction

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] b;
      do_reset();
      check("reset default outputs", {d_addr, d_data, d_wren, d_fd, d_err}, 0);
      check("reset small outputs", {s_addr, s_data, s_wren, s_fd, s_err}, 0);

      // Per-beat vector table on the 16x4 instance.
      add(1, 1, 0, 0, 0, 0, 0, 0, 0);              // beat before any in_first
      add(0, 1, 1, 1, 0, 0, 0, 0, 0);              // flags ignored without in_valid
      b = 8'hA5;
      for (int i = 0; i < 8; i++) add(1, b[i], i == 0, 0, i == 7, 16'd0, 8'hA5, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0);
      b = 8'h3C;
      for (int i = 0; i < 8; i++) add(1, b[i], 0, i == 7, i == 7, 16'd1, 8'h3C, 0, 0);
      for (int i = 0; i < 8; i++) add(1, 0, 0, 0, i == 7, 16'd2, 8'h00, 0, 0);
      for (int i = 0; i < 8; i++) add(1, 1, 0, 0, i == 7, 16'd3, 8'hFF, 0, 0);
      add(1, 1, 0, 0, 0, 0, 0, 0, 1);              // overlong beat
      add(1, 0, 0, 1, 0, 0, 0, 0, 1);              // overlong in_last, no write
      for (int i = 0; i < 3; i++) add(1, 1, 0, i == 2, i == 2, 16'd4, 8'h07, 0, 1);
      b = 8'h81;
      for (int i = 0; i < 8; i++) add(1, b[i], 0, 0, i == 7, 16'd6, 8'h81, 0, 1);
      b = 8'h7E;
      for (int i = 0; i < 8; i++) add(1, b[i], 0, i == 7, i == 7, 16'd7, 8'h7E, i == 7, 1);
      add(1, 1, 0, 0, 0, 0, 0, 0, 1);              // dropped after frame end
      add(1, 1, 1, 1, 1, 16'd0, 8'h01, 0, 1);      // one-pixel line
      for (int i = 0; i < tab.size(); i++) begin
         s_beat(tab[i].v, tab[i].p, tab[i].f, tab[i].l);
         check($sformatf("vec%0d wren", i), s_wren, tab[i].ew);
         if (tab[i].ew) begin
            check($sformatf("vec%0d addr", i), s_addr, tab[i].ea);
            check($sformatf("vec%0d data", i), s_data, tab[i].ed);
         end
         check($sformatf("vec%0d frame_done", i), s_fd, tab[i].efd);
         check($sformatf("vec%0d err", i), s_err, tab[i].eerr);
      end

      // Complete 16x4 frame with three set pixels.
      do_reset();
      for (int y = 0; y < 4; y++)
         for (int x = 0; x < 16; x++)
            s_beat(1, small_pix(x, y), x == 0 && y == 0, x == 15);
      for (int a = 0; a < 8; a++)
         exp_q.push_back({16'(a), (a == 2) ? 8'h02 : (a == 3) ? 8'h04 : (a == 6) ? 8'h20 : 8'h00});
      check("frame done count", fd_cnt, 1);
      check("frame done with last write", fd_addr, 16'd7);
      check("frame err", s_err, 0);
      compare_writes("small frame");

      // Default geometry: stray beats, then line 0 with pixel 8 set.
      do_reset();
      for (int i = 0; i < 100; i++)
         d_beat(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 0, 1'($urandom_range(1, 0)));
      check("pre-sof writes", got_q.size(), 0);
      got_q.delete();
      for (int x = 0; x < 640; x++) d_beat(1, x == 8, x == 0, x == 639);
      for (int i = 0; i < 80; i++) exp_q.push_back({16'(i), (i == 1) ? 8'h01 : 8'h00});
      compare_writes("line0");
      check("line0 err", d_err, 0);

      // Lines 1 and 2 with random gaps; each byte write must follow its beat by one cycle.
      for (int ln = 0; ln < 2; ln++)
         for (int x = 0; x < 640; x++) begin
            for (int g = 0; g < 3 && $urandom_range(1, 0) == 1; g++) begin
               d_beat(0, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
               check("gap beat wren", d_wren, 0);
            end
            pix_mem[ln][x] = 1'($urandom_range(1, 0));
            d_beat(1, pix_mem[ln][x], 0, x == 639);
            check("beat wren latency", d_wren, (x % 8) == 7);
         end
      for (int ln = 0; ln < 2; ln++)
         for (int bi = 0; bi < 80; bi++) begin
            for (int k = 0; k < 8; k++) b[k] = pix_mem[ln][bi * 8 + k];
            exp_q.push_back({16'((ln + 1) * 80 + bi), b});
         end
      compare_writes("gapped lines");
      check("gapped err", d_err, 0);

      // Short line at y=3, then the next line starts at its own row.
      for (int i = 0; i < 13; i++) d_beat(1, 1, 0, i == 12);
      exp_q.push_back({16'd240, 8'hFF});
      exp_q.push_back({16'd241, 8'h1F});
      compare_writes("short line");
      check("short line err", d_err, 1);
      for (int x = 0; x < 8; x++) d_beat(1, (x % 2) == 0, 0, 0);
      exp_q.push_back({16'd320, 8'h55});
      compare_writes("after short line");

      // Restart 5 beats into line 2.
      do_reset();
      for (int y = 0; y < 2; y++)
         for (int x = 0; x < 640; x++) d_beat(1, 0, x == 0 && y == 0, x == 639);
      check("two lines writes", got_q.size(), 160);
      got_q.delete();
      for (int i = 0; i < 5; i++) d_beat(1, 1, 0, 0);
      check("pre-restart err", d_err, 0);
      d_beat(1, 1, 1, 0);
      check("restart partial dropped", got_q.size(), 0);
      check("restart err", d_err, 1);
      for (int i = 0; i < 7; i++) d_beat(1, 0, 0, 0);
      exp_q.push_back({16'd0, 8'h01});
      compare_writes("after restart");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
